// File: rtl/core_mem_axi_loader_pkg.sv
// core_mem_axi_loader_pkg: shared AXI constants and the loader FSM state type.
//   BURST_INCR  - AXI4 INCR burst encoding
//   RESP_OKAY   - AXI4 OKAY response encoding
//   BOUNDARY_4K - bursts may not cross this address boundary
package core_mem_axi_loader_pkg;

  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam int unsigned BOUNDARY_4K = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_DROP,
    ST_WAIT_B,
    ST_STATUS
  } state_t;

endpackage

// File: rtl/core_mem_burst_calc.sv
// core_mem_burst_calc: combinational burst sizing.
//   addr        in  start byte address of the next burst
//   beats_rem   in  descriptor beats not yet issued on AW
//   burst_beats out min(beats_rem, MAX_BURST_LEN, beats left before the next 4 KB boundary)
module core_mem_burst_calc
  import core_mem_axi_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned BEAT_WIDTH    = 14,
  parameter int unsigned BURST_WIDTH   = 5,
  parameter int unsigned STRB_WIDTH    = 8,
  parameter int unsigned MAX_BURST_LEN = 16
) (
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [BEAT_WIDTH-1:0]  beats_rem,
  output logic [BURST_WIDTH-1:0] burst_beats
);

  localparam int unsigned SIZE = $clog2(STRB_WIDTH);

  logic [31:0] page_off;
  logic [31:0] to_bound;
  logic [31:0] best;

  // Smallest of the three limits; all arithmetic in 32 bits to avoid wrap.
  always_comb begin
    page_off = 32'(addr) & 32'(BOUNDARY_4K - 1);
    to_bound = (32'(BOUNDARY_4K) - page_off) >> SIZE;
    best     = 32'(MAX_BURST_LEN);
    if (32'(beats_rem) < best) best = 32'(beats_rem);
    if (to_bound < best) best = to_bound;
    burst_beats = BURST_WIDTH'(best);
  end

endmodule

// File: rtl/core_mem_axi_loader.sv
// core_mem_axi_loader: turns a write descriptor plus AXI-Stream payload into
// INCR AXI4 write bursts into a core's DMEM/IMEM, then reports one status.
//   s_desc_*    descriptor (addr, byte len, tag) handshake
//   s_axis_*    payload stream, full beats
//   m_axi_aw*   AXI4 write address, m_axi_w* write data, m_axi_b* write response
//   m_status_*  completion (tag, bytes written, error)
module core_mem_axi_loader
  import core_mem_axi_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned ID_WIDTH      = 8,
  parameter int unsigned LEN_WIDTH     = 16,
  parameter int unsigned TAG_WIDTH     = 8,
  parameter int unsigned MAX_BURST_LEN = 16,
  parameter int unsigned STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_desc_addr,
  input  logic [LEN_WIDTH-1:0]  s_desc_len,
  input  logic [TAG_WIDTH-1:0]  s_desc_tag,
  input  logic                  s_desc_valid,
  output logic                  s_desc_ready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [TAG_WIDTH-1:0]  m_status_tag,
  output logic [LEN_WIDTH-1:0]  m_status_len,
  output logic                  m_status_error,
  output logic                  m_status_valid,
  input  logic                  m_status_ready
);

  localparam int unsigned SIZE        = $clog2(STRB_WIDTH);
  localparam int unsigned CNT_WIDTH   = $clog2((2**LEN_WIDTH + STRB_WIDTH - 1) / STRB_WIDTH) + 1;
  localparam int unsigned BURST_WIDTH = $clog2(MAX_BURST_LEN) + 1;
  localparam int unsigned LENP_WIDTH  = LEN_WIDTH + 1;

  state_t                 state_q;
  logic [ADDR_WIDTH-1:0]  addr_next_q;
  logic [CNT_WIDTH-1:0]   beats_rem_q;
  logic [BURST_WIDTH-1:0] burst_left_q;
  logic [CNT_WIDTH-1:0]   out_cnt_q;
  logic [SIZE-1:0]        tail_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [LEN_WIDTH-1:0]   bytes_q;
  logic                   pad_q;
  logic                   err_q;

  logic                   desc_hs, aw_hs, w_hs, b_hs;
  logic                   final_beat, burst_end, stream_end;
  logic [CNT_WIDTH-1:0]   desc_beats;
  logic [ADDR_WIDTH-1:0]  calc_addr;
  logic [CNT_WIDTH-1:0]   calc_rem;
  logic [BURST_WIDTH-1:0] calc_beats;
  logic [STRB_WIDTH-1:0]  tail_strb;
  logic [LEN_WIDTH-1:0]   beat_bytes;
  logic [CNT_WIDTH-1:0]   out_cnt_nxt;
  logic                   err_nxt;
  logic                   unused_bid;

  assign unused_bid = ^m_axi_bid;

  assign m_axi_awid    = '0;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = BURST_INCR;

  // W channel is a pass-through of the stream; pad beats present zero strobes.
  assign m_axi_wvalid  = (state_q == ST_W) && (pad_q || s_axis_tvalid);
  assign m_axi_wdata   = (state_q == ST_W && !pad_q) ? s_axis_tdata : '0;
  assign m_axi_wlast   = (state_q == ST_W) && (burst_left_q == BURST_WIDTH'(1));
  assign m_axi_wstrb   = (state_q == ST_W && !pad_q) ? (final_beat ? tail_strb : '1) : '0;
  assign s_axis_tready = (state_q == ST_W && !pad_q && m_axi_wready) || (state_q == ST_DROP);

  // Burst sizing takes the new descriptor in IDLE, otherwise the running position.
  assign calc_addr = (state_q == ST_IDLE) ? s_desc_addr : addr_next_q;
  assign calc_rem  = (state_q == ST_IDLE) ? desc_beats : beats_rem_q;

  core_mem_burst_calc #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .BEAT_WIDTH   (CNT_WIDTH),
    .BURST_WIDTH  (BURST_WIDTH),
    .STRB_WIDTH   (STRB_WIDTH),
    .MAX_BURST_LEN(MAX_BURST_LEN)
  ) u_burst_calc (
    .addr       (calc_addr),
    .beats_rem  (calc_rem),
    .burst_beats(calc_beats)
  );

  // Handshakes, beat classification and counter look-ahead.
  always_comb begin
    desc_hs    = s_desc_valid && s_desc_ready;
    aw_hs      = m_axi_awvalid && m_axi_awready;
    w_hs       = m_axi_wvalid && m_axi_wready;
    b_hs       = m_axi_bvalid && m_axi_bready;
    desc_beats = CNT_WIDTH'(({1'b0, s_desc_len} + LENP_WIDTH'(STRB_WIDTH - 1)) >> SIZE);
    final_beat = (beats_rem_q == '0) && (burst_left_q == BURST_WIDTH'(1));
    burst_end  = (burst_left_q == BURST_WIDTH'(1));
    stream_end = pad_q || s_axis_tlast;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      tail_strb[i] = (tail_q == '0) || (i < int'(tail_q));
    end
    beat_bytes = LEN_WIDTH'(STRB_WIDTH);
    if (final_beat && tail_q != '0) beat_bytes = LEN_WIDTH'(tail_q);
    // A B with nothing outstanding is ignored for counting but flagged.
    out_cnt_nxt = out_cnt_q + CNT_WIDTH'(aw_hs)
                - CNT_WIDTH'(b_hs && (out_cnt_q != '0));
    err_nxt     = err_q | (b_hs && ((m_axi_bresp != RESP_OKAY) || (out_cnt_q == '0)));
  end

  // Loader FSM with registered AW, status and ready outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      addr_next_q    <= '0;
      beats_rem_q    <= '0;
      burst_left_q   <= '0;
      out_cnt_q      <= '0;
      tail_q         <= '0;
      tag_q          <= '0;
      bytes_q        <= '0;
      pad_q          <= 1'b0;
      err_q          <= 1'b0;
      s_desc_ready   <= 1'b0;
      m_axi_awaddr   <= '0;
      m_axi_awlen    <= '0;
      m_axi_awvalid  <= 1'b0;
      m_axi_bready   <= 1'b0;
      m_status_tag   <= '0;
      m_status_len   <= '0;
      m_status_error <= 1'b0;
      m_status_valid <= 1'b0;
    end else begin
      m_axi_bready <= 1'b1;
      out_cnt_q    <= out_cnt_nxt;
      err_q        <= err_nxt;
      case (state_q)
        ST_IDLE: begin
          s_desc_ready <= 1'b1;
          if (desc_hs) begin
            s_desc_ready <= 1'b0;
            tag_q        <= s_desc_tag;
            tail_q       <= s_desc_len[SIZE-1:0];
            err_q        <= 1'b0;
            bytes_q      <= '0;
            pad_q        <= 1'b0;
            if (desc_beats == '0) begin
              state_q <= ST_DROP;
            end else begin
              m_axi_awvalid <= 1'b1;
              m_axi_awaddr  <= calc_addr;
              m_axi_awlen   <= 8'(calc_beats - BURST_WIDTH'(1));
              burst_left_q  <= calc_beats;
              beats_rem_q   <= calc_rem - CNT_WIDTH'(calc_beats);
              addr_next_q   <= calc_addr + (ADDR_WIDTH'(calc_beats) << SIZE);
              state_q       <= ST_AW;
            end
          end
        end
        ST_AW: begin
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            state_q       <= ST_W;
          end
        end
        ST_W: begin
          if (w_hs) begin
            burst_left_q <= burst_left_q - BURST_WIDTH'(1);
            if (!pad_q) bytes_q <= bytes_q + beat_bytes;
            if (burst_end) begin
              pad_q <= 1'b0;
              if (stream_end) begin
                state_q <= ST_WAIT_B;
              end else if (beats_rem_q != '0) begin
                m_axi_awvalid <= 1'b1;
                m_axi_awaddr  <= calc_addr;
                m_axi_awlen   <= 8'(calc_beats - BURST_WIDTH'(1));
                burst_left_q  <= calc_beats;
                beats_rem_q   <= calc_rem - CNT_WIDTH'(calc_beats);
                addr_next_q   <= calc_addr + (ADDR_WIDTH'(calc_beats) << SIZE);
                state_q       <= ST_AW;
              end else begin
                state_q <= ST_DROP;
              end
            end else if (!pad_q && s_axis_tlast) begin
              // Stream ended early: pad out the rest of this burst only.
              pad_q <= 1'b1;
            end
          end
        end
        ST_DROP: begin
          if (s_axis_tvalid && s_axis_tlast) state_q <= ST_WAIT_B;
        end
        ST_WAIT_B: begin
          if (out_cnt_nxt == '0) begin
            m_status_valid <= 1'b1;
            m_status_tag   <= tag_q;
            m_status_len   <= bytes_q;
            m_status_error <= err_nxt;
            state_q        <= ST_STATUS;
          end
        end
        ST_STATUS: begin
          if (m_status_ready) begin
            m_status_valid <= 1'b0;
            state_q        <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_axi_loader.sv
// tb_core_mem_axi_loader: directed bench for core_mem_axi_loader with an
// AXI slave / stream source model, stability checks and hand-computed results.
`timescale 1ns/1ps
module tb_core_mem_axi_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_desc_addr;
  logic [15:0] s_desc_len;
  logic [7:0]  s_desc_tag;
  logic        s_desc_valid, s_desc_ready;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [7:0]  m_axi_awid;
  logic [15:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid, m_axi_awready;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [7:0]  m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic [7:0]  m_status_tag;
  logic [15:0] m_status_len;
  logic        m_status_error, m_status_valid, m_status_ready;

  always #5 clk = ~clk;

  core_mem_axi_loader #(
    .DATA_WIDTH(64), .ADDR_WIDTH(16), .ID_WIDTH(8), .LEN_WIDTH(16),
    .TAG_WIDTH(8), .MAX_BURST_LEN(16)
  ) dut (
    .clk(clk), .rst(rst),
    .s_desc_addr(s_desc_addr), .s_desc_len(s_desc_len), .s_desc_tag(s_desc_tag),
    .s_desc_valid(s_desc_valid), .s_desc_ready(s_desc_ready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_status_tag(m_status_tag), .m_status_len(m_status_len),
    .m_status_error(m_status_error), .m_status_valid(m_status_valid),
    .m_status_ready(m_status_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [7:0] tag, input int i);
    return {24'hC0DE00, tag, 32'(i)};
  endfunction

  // Results captured by run()
  logic [15:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  logic [7:0]  w_strb_q[$];
  logic [63:0] w_data_q[$];
  int          b_pend[$];
  int          wlast_cnt, consumed, b_done, pad_cnt, full_cnt, st_b;
  logic [15:0] st_len;
  logic [7:0]  st_tag;
  logic        st_err;
  logic [12:0] aw_static;

  // One descriptor transaction; stall randomises ready/valid gaps, abort_w stops after that many W beats.
  task automatic run(input logic [15:0] addr, input logic [15:0] len, input logic [7:0] tag,
                     input int nbeats, input int last_at, input bit stall,
                     input int err_burst, input int abort_w);
    int si = 0;
    int burst_idx = 0;
    bit desc_done = 0, done = 0, t_acc = 0, b_acc = 0;
    bit aw_wait = 0, w_wait = 0, st_wait = 0;
    logic [15:0] aw_addr_s = '0;
    logic [7:0]  aw_len_s = '0, w_strb_s = '0, st_tag_s = '0;
    logic [63:0] w_data_s = '0;
    logic        w_last_s = 0, st_err_s = 0;
    logic [15:0] st_len_s = '0;
    aw_addr_q.delete(); aw_len_q.delete(); w_strb_q.delete(); w_data_q.delete(); b_pend.delete();
    wlast_cnt = 0; consumed = 0; b_done = 0; pad_cnt = 0; full_cnt = 0; st_b = 0;
    st_len = '0; st_tag = '0; st_err = 1'b0; aw_static = '0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge clk);
      if (t_acc) begin si++; s_axis_tvalid = 1'b0; t_acc = 0; end
      if (b_acc) begin void'(b_pend.pop_front()); m_axi_bvalid = 1'b0; b_acc = 0; end
      s_desc_valid = !desc_done;
      s_desc_addr = addr; s_desc_len = len; s_desc_tag = tag;
      if (si < nbeats) begin
        if (!s_axis_tvalid) s_axis_tvalid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      end else begin
        s_axis_tvalid = 1'b0;
      end
      s_axis_tdata = pat(tag, si);
      s_axis_tlast = (si + 1 == last_at);
      m_axi_awready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_wready   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      m_status_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (b_pend.size() != 0 && !m_axi_bvalid)
        m_axi_bvalid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_bresp = (b_pend.size() != 0 && b_pend[0] == err_burst) ? 2'b10 : 2'b00;
      #1;
      if (aw_wait)
        check("aw_hold", {m_axi_awvalid, m_axi_awlen, m_axi_awaddr}, {1'b1, aw_len_s, aw_addr_s});
      if (w_wait) begin
        check("w_hold_data", m_axi_wdata, w_data_s);
        check("w_hold_ctl", {m_axi_wvalid, m_axi_wlast, m_axi_wstrb}, {1'b1, w_last_s, w_strb_s});
      end
      if (st_wait)
        check("st_hold", {m_status_valid, m_status_error, m_status_tag, m_status_len},
              {1'b1, st_err_s, st_tag_s, st_len_s});
      if (s_desc_valid && s_desc_ready) desc_done = 1;
      aw_wait = m_axi_awvalid && !m_axi_awready;
      aw_addr_s = m_axi_awaddr; aw_len_s = m_axi_awlen;
      if (m_axi_awvalid && m_axi_awready) begin
        aw_addr_q.push_back(m_axi_awaddr);
        aw_len_q.push_back(m_axi_awlen);
        aw_static = {m_axi_awid, m_axi_awsize, m_axi_awburst};
      end
      w_wait = m_axi_wvalid && !m_axi_wready;
      w_data_s = m_axi_wdata; w_strb_s = m_axi_wstrb; w_last_s = m_axi_wlast;
      if (m_axi_wvalid && m_axi_wready) begin
        w_strb_q.push_back(m_axi_wstrb);
        w_data_q.push_back(m_axi_wdata);
        if (m_axi_wstrb == 8'h00) pad_cnt++;
        if (m_axi_wstrb == 8'hFF) full_cnt++;
        if (m_axi_wlast) begin wlast_cnt++; b_pend.push_back(burst_idx); burst_idx++; end
      end
      if (s_axis_tvalid && s_axis_tready) begin t_acc = 1; consumed++; end
      if (m_axi_bvalid && m_axi_bready) begin b_acc = 1; b_done++; end
      st_wait = m_status_valid && !m_status_ready;
      st_len_s = m_status_len; st_tag_s = m_status_tag; st_err_s = m_status_error;
      if (m_status_valid && m_status_ready) begin
        st_len = m_status_len; st_tag = m_status_tag; st_err = m_status_error; st_b = b_done;
        done = 1;
      end
      if (abort_w != 0 && w_strb_q.size() >= abort_w) done = 1;
    end
    if (!done) check("timeout", 64'd0, 64'd1);
    @(negedge clk);
    s_desc_valid = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axi_bvalid = 1'b0;
  endtask

  task automatic check_status(input string name, input logic [15:0] len, input logic err,
                              input logic [7:0] tag);
    check({name, "_st"}, {st_tag, st_err, st_len}, {tag, err, len});
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_valids"},
          {s_desc_ready, s_axis_tready, m_axi_awvalid, m_axi_wvalid, m_axi_wlast,
           m_axi_bready, m_status_valid, m_status_error}, 8'h00);
    check({name, "_fields"}, {m_status_tag, m_status_len, m_axi_awaddr, m_axi_awlen, m_axi_wstrb}, 64'd0);
    check({name, "_wdata"}, m_axi_wdata, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    s_desc_addr = '0; s_desc_len = '0; s_desc_tag = '0; s_desc_valid = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bid = '0; m_axi_bresp = '0;
    m_axi_bvalid = 1'b0; m_status_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("bready_after_reset", m_axi_bready, 1'b1);

    // Basic single burst
    run(16'h0100, 16'd64, 8'h11, 8, 8, 0, -1, 0);
    check("basic_aw_cnt", aw_addr_q.size(), 1);
    check("basic_aw0", {aw_addr_q[0], aw_len_q[0]}, {16'h0100, 8'd7});
    check("basic_aw_static", aw_static, {8'h00, 3'd3, 2'b01});
    check("basic_w_cnt", {w_strb_q.size(), full_cnt}, {32'd8, 32'd8});
    check("basic_data7", w_data_q[7], pat(8'h11, 7));
    check_status("basic", 16'd64, 1'b0, 8'h11);

    // Two bursts, exact multiple of the beat size
    run(16'h8000, 16'd200, 8'h22, 25, 25, 0, -1, 0);
    check("split_aw", {aw_addr_q[0], aw_len_q[0], aw_addr_q[1], aw_len_q[1]},
          {16'h8000, 8'd15, 16'h8080, 8'd8});
    check("split_w", {w_strb_q.size(), full_cnt, wlast_cnt}, {32'd25, 32'd25, 32'd2});
    check("split_last_strb", w_strb_q[24], 8'hFF);
    check_status("split", 16'd200, 1'b0, 8'h22);

    // Partial final beat
    run(16'h8000, 16'd203, 8'h33, 26, 26, 0, -1, 0);
    check("part_aw1", {aw_addr_q[1], aw_len_q[1]}, {16'h8080, 8'd9});
    check("part_w", {w_strb_q.size(), full_cnt}, {32'd26, 32'd25});
    check("part_last_strb", w_strb_q[25], 8'h07);
    check_status("part", 16'd203, 1'b0, 8'h33);

    // 4 KB boundary split
    run(16'h0FF0, 16'd64, 8'h44, 8, 8, 0, -1, 0);
    check("4k_aw", {aw_addr_q[0], aw_len_q[0], aw_addr_q[1], aw_len_q[1]},
          {16'h0FF0, 8'd1, 16'h1000, 8'd5});
    check("4k_w", {w_strb_q.size(), wlast_cnt}, {32'd8, 32'd2});
    check_status("4k", 16'd64, 1'b0, 8'h44);

    // Early tlast: pad the rest of the burst
    run(16'h0200, 16'd64, 8'h55, 3, 3, 0, -1, 0);
    check("early_aw", {aw_addr_q.size(), aw_len_q[0]}, {32'd1, 8'd7});
    check("early_w", {w_strb_q.size(), pad_cnt, consumed}, {32'd8, 32'd5, 32'd3});
    check("early_data2", w_data_q[2], pat(8'h55, 2));
    check_status("early", 16'd24, 1'b0, 8'h55);

    // Overlong stream under random backpressure
    run(16'h0300, 16'd16, 8'h66, 5, 5, 1, -1, 0);
    check("long_aw", {aw_addr_q.size(), aw_addr_q[0], aw_len_q[0]}, {32'd1, 16'h0300, 8'd1});
    check("long_w", {w_strb_q.size(), full_cnt, consumed}, {32'd2, 32'd2, 32'd5});
    check("long_data1", w_data_q[1], pat(8'h66, 1));
    check_status("long", 16'd16, 1'b0, 8'h66);

    // SLVERR on the middle of three bursts
    run(16'h0000, 16'd384, 8'h70, 48, 48, 0, 1, 0);
    check("err_aw", {aw_addr_q.size(), aw_addr_q[2]}, {32'd3, 16'h0100});
    check("err_b_before_status", st_b, 3);
    check_status("err", 16'd384, 1'b1, 8'h70);

    // Zero-length descriptor: drop the stream, no bursts, error cleared
    run(16'h0600, 16'd0, 8'h7A, 1, 1, 0, -1, 0);
    check("zero_cnt", {aw_addr_q.size(), w_strb_q.size(), consumed}, {32'd0, 32'd0, 32'd1});
    check_status("zero", 16'd0, 1'b0, 8'h7A);

    // Reset in the middle of a W burst
    run(16'h0400, 16'd64, 8'h77, 8, 8, 0, -1, 3);
    check("abort_w_seen", w_strb_q.size(), 3);
    s_axis_tvalid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    s_axis_tvalid = 1'b0;

    // Recovery after reset
    run(16'h0500, 16'd32, 8'h88, 4, 4, 0, -1, 0);
    check("recover_aw", {aw_addr_q.size(), aw_addr_q[0], aw_len_q[0]}, {32'd1, 16'h0500, 8'd3});
    check_status("recover", 16'd32, 1'b0, 8'h88);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
